// File: rtl/aes_key_expand.sv
// aes_key_expand: streaming AES-128/192/256 key schedule generator.
// Emits one 32-bit schedule word per cycle over a valid/ready handshake.
module aes_key_expand #(
  parameter  int NK = 4,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [32*NK-1:0] key_in,
  output logic            busy,
  output logic            word_valid,
  input  logic            word_ready,
  output logic [5:0]      word_idx,
  output logic [31:0]     word_out,
  output logic            done
);

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_key_expand: NK must be 4, 6 or 8");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0 of the table sits in the MSBs, so entry x starts at bit 8*(255-x)+7.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  logic [1:0]  r_state;
  logic [31:0] r_win [NK];
  logic [5:0]  r_idx;
  logic [2:0]  r_mod;
  logic [7:0]  r_rcon;
  logic        r_busy;
  logic        r_valid;
  logic        r_done;

  logic        w_hs;
  logic        w_last;
  logic        w_in_key;
  logic [2:0]  w_mod_nx;
  logic [7:0]  w_rcon_nx;
  logic [31:0] w_cur;
  logic [31:0] w_sin;
  logic [31:0] w_sout;
  logic [31:0] w_temp;
  logic [31:0] w_next;

  // The newest window slot is the word on word_out (w[i]); slot 0 holds w[i+1-NK].
  assign w_cur      = r_win[NK-1];
  assign w_hs       = r_valid & word_ready;
  assign w_last     = (r_idx == 6'(NW-1));
  assign w_in_key   = (r_idx < 6'(NK-1));
  assign w_mod_nx   = (r_mod == 3'(NK-1)) ? 3'd0 : r_mod + 3'd1;
  assign w_rcon_nx  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

  // Next schedule word w[i+1]: key words pass through, later words mix in temp.
  always_comb begin
    w_sin  = (w_mod_nx == 3'd0) ? {w_cur[23:0], w_cur[31:24]} : w_cur;
    w_sout = {sbox(w_sin[31:24]), sbox(w_sin[23:16]),
              sbox(w_sin[15:8]),  sbox(w_sin[7:0])};
    w_temp = w_cur;
    if (w_mod_nx == 3'd0) begin
      w_temp = w_sout ^ {r_rcon, 24'h0};
    end else if (NK == 8 && w_mod_nx == 3'd4) begin
      w_temp = w_sout;
    end
    w_next = w_in_key ? r_win[0] : (r_win[0] ^ w_temp);
  end

  // Control FSM, window shift register and rcon generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 6'd0;
      r_mod   <= 3'd0;
      r_rcon  <= 8'h01;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < NK; k++) begin
        r_win[k] <= 32'h0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Load rotated so slot 0 always presents the next key word.
            for (int k = 0; k < NK - 1; k++) begin
              r_win[k] <= key_in[32*(NK-1-k)-1 -: 32];
            end
            r_win[NK-1] <= key_in[32*NK-1 -: 32];
            r_idx   <= 6'd0;
            r_mod   <= 3'd0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_GEN;
          end
        end
        S_GEN: begin
          if (w_hs) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              for (int k = 0; k < NK - 1; k++) begin
                r_win[k] <= r_win[k+1];
              end
              r_win[NK-1] <= w_next;
              r_idx <= r_idx + 6'd1;
              r_mod <= w_mod_nx;
              if (r_mod == 3'd0 && r_idx >= 6'(NK)) begin
                r_rcon <= w_rcon_nx;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign word_valid = r_valid;
  assign word_idx   = r_idx;
  assign word_out   = w_cur;
  assign done       = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed bench for the streaming AES key schedule.
// One instance per key length; a reference schedule is built in the bench.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic         ready;
  logic [255:0] key;
  int           sel;

  logic st4, st6, st8;
  logic b4, b6, b8, v4, v6, v8, d4, d6, d8;
  logic [5:0]  i4, i6, i8;
  logic [31:0] o4, o6, o8;

  logic        c_busy, c_valid, c_done;
  logic [5:0]  c_idx;
  logic [31:0] c_word;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  sb_ref [256];
  logic [31:0] exp_w  [60];
  logic [7:0]  rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                 128'h0};
  localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                 64'h0};
  localparam logic [255:0] K8 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  assign st4 = start & (sel == 4);
  assign st6 = start & (sel == 6);
  assign st8 = start & (sel == 8);

  aes_key_expand #(.NK(4)) u_nk4 (
    .clk(clk), .rst(rst), .start(st4), .key_in(key[255 -: 128]),
    .busy(b4), .word_valid(v4), .word_ready(ready),
    .word_idx(i4), .word_out(o4), .done(d4)
  );

  aes_key_expand #(.NK(6)) u_nk6 (
    .clk(clk), .rst(rst), .start(st6), .key_in(key[255 -: 192]),
    .busy(b6), .word_valid(v6), .word_ready(ready),
    .word_idx(i6), .word_out(o6), .done(d6)
  );

  aes_key_expand #(.NK(8)) u_nk8 (
    .clk(clk), .rst(rst), .start(st8), .key_in(key),
    .busy(b8), .word_valid(v8), .word_ready(ready),
    .word_idx(i8), .word_out(o8), .done(d8)
  );

  always_comb begin
    c_busy  = b4;
    c_valid = v4;
    c_done  = d4;
    c_idx   = i4;
    c_word  = o4;
    case (sel)
      6: begin
        c_busy = b6; c_valid = v6; c_done = d6; c_idx = i6; c_word = o6;
      end
      8: begin
        c_busy = b8; c_valid = v8; c_done = d8; c_idx = i8; c_word = o8;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s nk=%0d got=%h exp=%h", tag, sel, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int j = 0; j < 8; j++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int j = 0; j < n; j++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: GF(2^8) inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h0;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb_ref[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_ref[w[31:24]], sb_ref[w[23:16]], sb_ref[w[15:8]], sb_ref[w[7:0]]};
  endfunction

  task automatic build_sched(input int nk, input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        exp_w[i] = k[255 - 32*i -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc_tab[i/nk - 1], 24'h0};
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  32'(c_busy),  32'd0);
    check({tag, "_valid"}, 32'(c_valid), 32'd0);
    check({tag, "_done"},  32'(c_done),  32'd0);
    check({tag, "_idx"},   32'(c_idx),   32'd0);
    check({tag, "_word"},  c_word,       32'h0);
  endtask

  task automatic run(input int nk, input logic [255:0] k, input bit rnd,
                     input bit glitch, input bit abort,
                     input int h0, input logic [31:0] v0,
                     input int h1, input logic [31:0] v1,
                     input int h2, input logic [31:0] v2);
    int nw;
    int n;
    int cyc;
    bit gl;
    nw = 4 * (nk + 7);
    build_sched(nk, k);
    sel   = nk;
    key   = k;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n   = 0;
    cyc = 0;
    gl  = 1'b0;
    while (n < nw) begin
      if (cyc >= 20 * nw) begin
        check("timeout", 32'(n), 32'(nw));
        return;
      end
      check("valid", 32'(c_valid), 32'd1);
      check("busy",  32'(c_busy),  32'd1);
      check("early_done", 32'(c_done), 32'd0);
      check("idx",  32'(c_idx), 32'(n));
      check("word", c_word, exp_w[n]);
      if (n == h0) check("vec_a", c_word, v0);
      if (n == h1) check("vec_b", c_word, v1);
      if (n == h2) check("vec_c", c_word, v2);
      if (abort && n == 20) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("abort");
        repeat (3) begin
          @(posedge clk); #1;
          check("abort_no_done",  32'(c_done),  32'd0);
          check("abort_no_valid", 32'(c_valid), 32'd0);
        end
        return;
      end
      if (glitch && n == 10 && !gl) begin
        start = 1'b1;
        key   = ~k;
        gl    = 1'b1;
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (ready) n++;
    end
    check("done",      32'(c_done),  32'd1);
    check("done_busy", 32'(c_busy),  32'd0);
    check("done_vld",  32'(c_valid), 32'd0);
    if (!rnd) check("cycles", 32'(cyc), 32'(nw));
    ready = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", 32'(c_done), 32'd0);
    check("post_busy",  32'(c_busy), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    key   = '0;
    sel   = 4;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 4; s <= 8; s += 2) begin
      sel = s;
      #1;
      check_idle_zero("reset");
    end
    rst = 1'b0;
    sel = 4;
    @(posedge clk); #1;
    check_idle_zero("idle");

    run(4, K4, 1'b0, 1'b0, 1'b0,
        4, 32'ha0fafe17, 43, 32'hb6630ca6, -1, 32'h0);
    run(6, K6, 1'b0, 1'b0, 1'b0,
        6, 32'hfe0c91f7, 51, 32'h01002202, -1, 32'h0);
    run(8, K8, 1'b0, 1'b0, 1'b0,
        8, 32'h9ba35411, 12, 32'ha8b09c1a, 59, 32'h706c631e);
    run(4, K4, 1'b1, 1'b0, 1'b0,
        4, 32'ha0fafe17, 43, 32'hb6630ca6, -1, 32'h0);
    run(4, K4, 1'b0, 1'b1, 1'b0,
        4, 32'ha0fafe17, 43, 32'hb6630ca6, -1, 32'h0);
    run(4, K4, 1'b0, 1'b0, 1'b1,
        4, 32'ha0fafe17, -1, 32'h0, -1, 32'h0);
    run(4, K4, 1'b0, 1'b0, 1'b0,
        4, 32'ha0fafe17, 43, 32'hb6630ca6, -1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES key-expansion engine, parametrised for AES-128/192/256 via key length NK. It replaces the fixed per-round constant lookup with an on-the-fly Rcon generator (GF(2^8) doubling) and streams the full expanded key schedule, one 32-bit word per cycle, over a valid/ready handshake. It sits between the key register and the round-key store of the encryption datapath.

## Interface
- NK, default 4, key length in 32-bit words; legal values 4, 6, 8 only, and any other value is an elaboration error
- NR, derived NK+6, round count; not user-overridable
- NW, derived 4*(NR+1), total words: 44, 52 or 60
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin expansion; sampled only in IDLE
- key_in  input  32*NK  cipher key; bits [32*NK-1 -: 32] are w[0] (FIPS-197 byte order, byte 0 in MSB)
- busy  output  1  high from the cycle after accepted start until done
- word_valid  output  1  word_out/word_idx hold a valid schedule word
- word_ready  input  1  consumer accepts the word this cycle
- word_idx  output  6  index i of word_out, 0..NW-1
- word_out  output  32  schedule word w[i]
- done  output  1  one-cycle pulse after last word accepted

## Operation
- FSM states: IDLE, GEN, DONE.
- IDLE: start=1 captures key_in into an NK-word window register, loads rcon=8'h01 and i=0, and moves to GEN. start=0 stays in IDLE.
- GEN: word_valid=1. word_out=w[i].
  - For i<NK, w[i] is key word i.
  - For i>=NK: temp=w[i-1].
    - If i mod NK==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}.
    - Else if NK==8 and i mod NK==4: temp=SubWord(temp).
    - Then w[i]=w[i-NK]^temp.
- SubWord: four S-box instances, byte-wise. RotWord: {b1,b2,b3,b0}.
- The i mod NK counter is a separate 3-bit counter that wraps at NK. No divider.
- On handshake (word_valid & word_ready):
  - Shift w[i] into the window.
  - Increment i.
  - If a word with i mod NK==0 (i>=NK) was just accepted, advance rcon={rcon[6:0],1'b0}^(rcon[7]?8'h1B:8'h00).
  - If i==NW-1, go to DONE.
- No handshake: all outputs and state hold unchanged (word stable under backpressure).
- DONE: done=1 for one cycle, busy=0, word_valid=0, then IDLE.
- start while busy or in DONE: ignored, with no restart.
- key_in changes after capture have no effect.

## Timing
- Reset values: busy=0, word_valid=0, word_idx=0, word_out=32'h0, done=0, state IDLE, rcon=8'h01, window cleared.
- rst asserted mid-expansion aborts immediately to the reset state. No done pulse is issued.
- Start latency: start in cycle T gives word_valid=1 with w[0] in T+1.
- Throughput: with word_ready held high, words 0..NW-1 appear in consecutive cycles T+1..T+NW. done pulses in T+NW+1.
- busy is high T+1..T+NW and low in the done cycle.
- Next start is accepted in the cycle after done.
- All outputs are registered. The combinational path is window to S-box to XOR into the word_out register, and must close timing in one cycle.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36. NK=4 uses all 10, NK=6 uses 8, NK=8 uses 7.

## Test plan
- NK=4, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, ready=1 -> w[4]=a0fafe17, w[43]=b6630ca6, 44 consecutive valid cycles, done at T+45.
- NK=6, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> w[6]=fe0c91f7, w[51]=01002202, 52 words.
- NK=8, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path), w[59]=706c631e.
- NK=4 with random word_ready toggling -> word_out/word_idx stable while ready=0, full sequence identical to the ready=1 run, done only after w[43] is accepted.
- start pulsed at word_idx=10 with a different key_in -> ignored; the schedule completes with the original key.
- rst asserted at word_idx=20 -> next cycle all outputs are 0 and no done pulse; a new start reproduces w[0..43] correctly with rcon restarting at 01.
